// File: rtl/apb_audio_play_ctrl_pkg.sv
// rtl/apb_audio_play_ctrl_pkg.sv - register map, bit indices and FSM encoding for the audio play controller
package apb_audio_play_ctrl_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STAT     = 3'd1;
    localparam logic [2:0] REG_SEG_BASE = 3'd2;
    localparam logic [2:0] REG_SEG_LEN  = 3'd3;
    localparam logic [2:0] REG_ITR_EN   = 3'd4;
    localparam logic [2:0] REG_ITR_STS  = 3'd5;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_LOOP     = 2;
    localparam int CTRL_RATE_LSB = 4;

    localparam int ITR_SEG_DONE = 0;
    localparam int ITR_ALL_DONE = 1;
    localparam int ITR_FIFO_OVF = 2;
    localparam int ITR_GLOBAL   = 8;

    localparam int SEG_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT       = 2'd2,
        ST_ABORT_WAIT = 2'd3
    } play_state_e;

    typedef struct packed {
        logic [SEG_W-1:0] base;
        logic [SEG_W-1:0] len;
    } seg_t;

endpackage

// File: rtl/apb_audio_play_ctrl_if.sv
// rtl/apb_audio_play_ctrl_if.sv - APB register bus bundle for the audio play controller
interface apb_audio_play_ctrl_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/audio_seg_queue.sv
// rtl/audio_seg_queue.sv - register-based segment FIFO with flush and simultaneous push/pop
module audio_seg_queue #(
    parameter int depth = 4,
    parameter int width = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [width-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [width-1:0]       head_data,
    output logic [$clog2(depth):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    rd_ptr;
    logic [aw-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (aw+1)'(depth));
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop & ~empty;
    // A full queue still takes a push when the head leaves in the same cycle (loop re-queue).
    assign do_push   = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + aw'(1);
            if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
            count <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/apb_audio_play_ctrl.sv
// rtl/apb_audio_play_ctrl.sv - APB front-end queueing flash audio segments and issuing them to the DMA
module apb_audio_play_ctrl
    import apb_audio_play_ctrl_pkg::*;
#(
    parameter int         seg_queue_depth        = 4,
    parameter logic [2:0] init_audio_sample_rate = 3'd3
) (
    input  logic                  amba_clk,
    input  logic                  amba_resetn,
    apb_audio_play_ctrl_if.slave  apb,
    output logic [2:0]            audio_sample_rate,
    output logic                  dma_req,
    output logic                  dma_abort,
    output logic [SEG_W-1:0]      flash_rd_baseaddr,
    output logic [SEG_W-1:0]      flash_rd_bytes_n,
    input  logic                  dma_done,
    input  logic                  dma_idle,
    input  logic                  spi_tx_fifo_wt_ovf,
    input  logic                  spi_rx_fifo_wt_ovf,
    output logic                  itr
);
    localparam int CW = $clog2(seg_queue_depth) + 1;

    play_state_e      state;
    play_state_e      state_next;
    logic             run;
    logic             loop_en;
    logic [SEG_W-1:0] seg_base;
    logic             itr_global;
    logic [2:0]       itr_en;
    logic [2:0]       itr_sts;
    logic             tx_ovf_q;
    logic             rx_ovf_q;

    logic [2:0]       reg_idx;
    logic             apb_wr;
    logic             apb_rd;
    logic             wr_ctrl;
    logic             wr_seg_len;
    logic             abort_req;
    logic             pop_evt;
    logic             loop_push;
    logic             seg_ok;
    logic             apb_push;
    logic             all_done_evt;
    logic             ovf_evt;
    logic [2:0]       sts_clr;
    logic [31:0]      rdata;

    seg_t             q_head;
    seg_t             q_push_data;
    logic [CW-1:0]    q_count;
    logic             q_full;
    logic             q_empty;

    logic             unused_apb_bits;

    assign reg_idx    = apb.paddr[4:2];
    assign apb_wr     = apb.psel & apb.penable & apb.pwrite;
    assign apb_rd     = apb.psel & apb.penable & ~apb.pwrite;
    assign wr_ctrl    = apb_wr & (reg_idx == REG_CTRL);
    assign wr_seg_len = apb_wr & (reg_idx == REG_SEG_LEN);
    assign abort_req  = wr_ctrl & apb.pwdata[CTRL_ABORT];

    // Abort pre-empts a same-cycle completion: nothing is popped and seg_done stays clear.
    assign pop_evt   = (state == ST_WAIT) & dma_done & ~abort_req;
    assign loop_push = pop_evt & loop_en;

    // Fullness is judged before any same-cycle pop; the loop re-queue owns the single push slot.
    assign seg_ok       = (apb.pwdata[SEG_W-1:0] >= SEG_W'(2)) & ~q_full & ~loop_push;
    assign apb_push     = wr_seg_len & seg_ok;
    assign all_done_evt = pop_evt & ~loop_en & ~apb_push & (q_count == CW'(1));
    assign ovf_evt      = (spi_tx_fifo_wt_ovf & ~tx_ovf_q) | (spi_rx_fifo_wt_ovf & ~rx_ovf_q);
    assign sts_clr      = (apb_wr && reg_idx == REG_ITR_STS) ? apb.pwdata[2:0] : 3'b000;

    assign q_push_data = loop_push ? q_head : seg_t'({seg_base, apb.pwdata[SEG_W-1:0]});

    audio_seg_queue #(
        .depth (seg_queue_depth),
        .width (2 * SEG_W)
    ) u_seg_queue (
        .clk       (amba_clk),
        .rst_n     (amba_resetn),
        .push      (loop_push | apb_push),
        .push_data (q_push_data),
        .pop       (pop_evt),
        .flush     (abort_req),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        state_next = state;
        if (abort_req) begin
            state_next = ST_ABORT_WAIT;
        end else begin
            case (state)
                ST_IDLE:       if (run && !q_empty && dma_idle) state_next = ST_ISSUE;
                ST_ISSUE:      state_next = ST_WAIT;
                ST_WAIT:       if (pop_evt) state_next = ST_IDLE;
                ST_ABORT_WAIT: if (dma_idle) state_next = ST_IDLE;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge amba_clk or negedge amba_resetn) begin
        if (!amba_resetn) begin
            state             <= ST_IDLE;
            run               <= 1'b0;
            loop_en           <= 1'b0;
            audio_sample_rate <= init_audio_sample_rate;
            seg_base          <= '0;
            itr_global        <= 1'b0;
            itr_en            <= 3'b000;
            itr_sts           <= 3'b000;
            itr               <= 1'b0;
            dma_req           <= 1'b0;
            dma_abort         <= 1'b0;
            flash_rd_baseaddr <= '0;
            flash_rd_bytes_n  <= '0;
            tx_ovf_q          <= 1'b0;
            rx_ovf_q          <= 1'b0;
        end else begin
            state     <= state_next;
            dma_req   <= (state_next == ST_ISSUE);
            dma_abort <= abort_req;
            if (state_next == ST_ISSUE) begin
                flash_rd_baseaddr <= q_head.base;
                flash_rd_bytes_n  <= q_head.len;
            end
            if (wr_ctrl) begin
                loop_en           <= apb.pwdata[CTRL_LOOP];
                audio_sample_rate <= apb.pwdata[CTRL_RATE_LSB +: 3];
            end
            if (abort_req || all_done_evt) run <= 1'b0;
            else if (wr_ctrl)              run <= apb.pwdata[CTRL_RUN];
            if (apb_wr && reg_idx == REG_SEG_BASE) seg_base <= apb.pwdata[SEG_W-1:0];
            if (apb_wr && reg_idx == REG_ITR_EN) begin
                itr_global <= apb.pwdata[ITR_GLOBAL];
                itr_en     <= apb.pwdata[2:0];
            end
            tx_ovf_q <= spi_tx_fifo_wt_ovf;
            rx_ovf_q <= spi_rx_fifo_wt_ovf;
            // Sticky set is OR-ed after the clear so a same-cycle event survives W1C.
            itr_sts  <= (itr_sts & ~sts_clr) | {ovf_evt, all_done_evt, pop_evt};
            itr      <= itr_global & |(itr_sts & itr_en);
        end
    end

    always_comb begin
        rdata = '0;
        if (apb_rd) begin
            case (reg_idx)
                REG_CTRL: begin
                    rdata[CTRL_RUN]              = run;
                    rdata[CTRL_LOOP]             = loop_en;
                    rdata[CTRL_RATE_LSB +: 3]    = audio_sample_rate;
                end
                REG_STAT: begin
                    rdata[0]   = (state != ST_IDLE);
                    rdata[1]   = dma_idle;
                    rdata[5:2] = 4'(q_count);
                    rdata[6]   = q_full;
                end
                REG_SEG_BASE: rdata[SEG_W-1:0] = seg_base;
                REG_ITR_EN: begin
                    rdata[ITR_GLOBAL] = itr_global;
                    rdata[2:0]        = itr_en;
                end
                REG_ITR_STS: rdata[2:0] = itr_sts;
                default:     rdata = '0;
            endcase
        end
    end

    assign apb.prdata  = rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = wr_seg_len & ~seg_ok;

    assign unused_apb_bits = ^{apb.paddr[31:5], apb.paddr[1:0], apb.pwdata[31:24]};
endmodule

// File: tb/tb_apb_audio_play_ctrl.sv
// tb/tb_apb_audio_play_ctrl.sv - self-checking bench for apb_audio_play_ctrl
module tb_apb_audio_play_ctrl;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_BASE = 32'h08;
    localparam logic [31:0] A_LEN = 32'h0C, A_EN = 32'h10, A_STS = 32'h14;

    logic amba_clk = 1'b0;
    logic amba_resetn = 1'b0;
    always #5 amba_clk = ~amba_clk;

    apb_audio_play_ctrl_if apb_bus ();

    logic [2:0]  audio_sample_rate;
    logic        dma_req, dma_abort, itr;
    logic [23:0] flash_rd_baseaddr, flash_rd_bytes_n;
    logic        dma_done = 1'b0, dma_idle = 1'b0;
    logic        spi_tx_fifo_wt_ovf = 1'b0, spi_rx_fifo_wt_ovf = 1'b0;

    apb_audio_play_ctrl #(
        .seg_queue_depth        (DEPTH),
        .init_audio_sample_rate (3'd3)
    ) dut (
        .amba_clk           (amba_clk),
        .amba_resetn        (amba_resetn),
        .apb                (apb_bus),
        .audio_sample_rate  (audio_sample_rate),
        .dma_req            (dma_req),
        .dma_abort          (dma_abort),
        .flash_rd_baseaddr  (flash_rd_baseaddr),
        .flash_rd_bytes_n   (flash_rd_bytes_n),
        .dma_done           (dma_done),
        .dma_idle           (dma_idle),
        .spi_tx_fifo_wt_ovf (spi_tx_fifo_wt_ovf),
        .spi_rx_fifo_wt_ovf (spi_rx_fifo_wt_ovf),
        .itr                (itr)
    );

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    int abort_cnt = 0;
    logic [23:0] cap_base = '0, cap_len = '0;

    // Reference model: segment list plus the software-visible control/status bits
    logic [47:0] mq[$];
    bit          m_run = 0, m_loop = 0;
    logic [2:0]  m_rate = 3'd3;
    logic [2:0]  m_sts = 3'd0;

    always @(negedge amba_clk) begin
        if (dma_req) begin
            req_cnt  <= req_cnt + 1;
            cap_base <= flash_rd_baseaddr;
            cap_len  <= flash_rd_bytes_n;
        end
        if (dma_abort) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge amba_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit with_done,
                            output logic [31:0] rd, output logic err);
        apb_bus.paddr = a; apb_bus.pwdata = d; apb_bus.pwrite = wr;
        apb_bus.psel = 1'b1; apb_bus.penable = 1'b0;
        tick();
        apb_bus.penable = 1'b1;
        dma_done = with_done;
        #1;
        rd = apb_bus.prdata;
        err = apb_bus.pslverr;
        tick();
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
        dma_done = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; logic e;
        apb_xfer(a, d, 1'b1, 1'b0, r, e);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; logic e;
        apb_xfer(a, 32'h0, 1'b0, 1'b0, r, e);
        check(tag, r, exp);
    endtask

    function automatic logic [31:0] exp_stat(bit busy, bit idle);
        return {25'd0, mq.size() == DEPTH, 4'(mq.size()), idle, busy};
    endfunction

    function automatic logic [31:0] exp_ctrl();
        return {25'd0, m_rate, 1'b0, m_loop, 1'b0, m_run};
    endfunction

    task automatic push_seg(input string tag, input logic [23:0] base, input logic [23:0] len);
        logic [31:0] r; logic e; bit exp_err;
        exp_err = (mq.size() == DEPTH) || (len < 24'd2);
        apb_xfer(A_BASE, {8'h0, base}, 1'b1, 1'b0, r, e);
        apb_xfer(A_LEN, {8'h0, len}, 1'b1, 1'b0, r, e);
        check({tag, "_pslverr"}, {31'd0, e}, {31'd0, exp_err});
        if (!exp_err) mq.push_back({base, len});
    endtask

    task automatic wait_req(input string tag);
        int n0, k;
        n0 = req_cnt; k = 0;
        while (req_cnt == n0 && k < 40) begin tick(); k++; end
        check({tag, "_req_pulses"}, req_cnt - n0, 1);
        check({tag, "_base"}, {8'h0, cap_base}, {8'h0, mq[0][47:24]});
        check({tag, "_len"}, {8'h0, cap_len}, {8'h0, mq[0][23:0]});
    endtask

    task automatic done_pulse();
        logic [47:0] e;
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        e = mq.pop_front();
        m_sts[0] = 1'b1;
        if (m_loop) mq.push_back(e);
        else if (mq.size() == 0) begin m_sts[1] = 1'b1; m_run = 0; end
    endtask

    function automatic logic [23:0] rnd_base();
        return 24'($urandom);
    endfunction

    function automatic logic [23:0] rnd_len();
        return 24'($urandom_range(2, 32'h00FF_FFFF));
    endfunction

    initial begin
        int n0;
        logic [2:0] r;
        apb_bus.paddr = '0; apb_bus.pwdata = '0; apb_bus.pwrite = 1'b0;
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;

        repeat (3) tick();
        check("rst_dma_req", {31'd0, dma_req}, 0);
        check("rst_dma_abort", {31'd0, dma_abort}, 0);
        check("rst_itr", {31'd0, itr}, 0);
        check("rst_pready", {31'd0, apb_bus.pready}, 1);
        check("rst_rate", {29'd0, audio_sample_rate}, 3);
        check("rst_flash", {flash_rd_baseaddr[7:0], flash_rd_bytes_n}, 0);
        amba_resetn = 1'b1;
        tick();
        rd_check("rst_stat", A_STAT, exp_stat(0, 0));
        rd_check("rst_ctrl", A_CTRL, exp_ctrl());
        rd_check("unmapped_read", 32'h18, 0);

        // Two queued segments played back to back
        push_seg("t1_s0", 24'h001000, 24'd256);
        push_seg("t1_s1", 24'h002000, 24'd512);
        rd_check("t1_count2", A_STAT, exp_stat(0, 0));
        wr_reg(A_CTRL, 32'h31); m_run = 1;
        dma_idle = 1'b1;
        wait_req("t1_first");
        n0 = req_cnt;
        repeat (5) tick();
        check("t1_no_early_issue", req_cnt - n0, 0);
        dma_idle = 1'b0;
        done_pulse();
        rd_check("t1_count1", A_STAT, exp_stat(0, 0));
        dma_idle = 1'b1;
        wait_req("t1_second");
        dma_idle = 1'b0;
        done_pulse();
        rd_check("t1_count0", A_STAT, exp_stat(0, 0));
        rd_check("t1_sts", A_STS, {29'd0, m_sts});
        rd_check("t1_ctrl", A_CTRL, exp_ctrl());

        // Loop playback of one random segment
        wr_reg(A_STS, 32'h7); m_sts = 0;
        push_seg("t2_s0", rnd_base(), rnd_len());
        wr_reg(A_CTRL, 32'h35); m_run = 1; m_loop = 1;
        for (int i = 0; i < 3; i++) begin
            dma_idle = 1'b1;
            wait_req("t2_loop");
            dma_idle = 1'b0;
            done_pulse();
            rd_check("t2_count", A_STAT, exp_stat(0, 0));
        end
        rd_check("t2_ctrl_run", A_CTRL, exp_ctrl());
        wr_reg(A_CTRL, 32'h30); m_run = 0; m_loop = 0;
        dma_idle = 1'b1;
        n0 = abort_cnt;
        wr_reg(A_CTRL, 32'h32); mq.delete();
        repeat (2) tick();
        check("t2_abort_pulse", abort_cnt - n0, 1);
        rd_check("t2_flushed", A_STAT, exp_stat(0, 1));

        // Queue overflow and short-length rejection
        wr_reg(A_STS, 32'h7); m_sts = 0;
        push_seg("t3_short", rnd_base(), 24'($urandom_range(0, 1)));
        rd_check("t3_short_count", A_STAT, exp_stat(0, 1));
        for (int i = 0; i < 5; i++) push_seg("t3_fill", rnd_base(), rnd_len());
        rd_check("t3_full", A_STAT, exp_stat(0, 1));

        // Abort colliding with dma_done while waiting
        wr_reg(A_CTRL, 32'h31); m_run = 1;
        wait_req("t4_issue");
        dma_idle = 1'b0;
        n0 = abort_cnt;
        begin
            logic [31:0] rr; logic ee;
            apb_xfer(A_CTRL, 32'h32, 1'b1, 1'b1, rr, ee);
        end
        mq.delete(); m_run = 0;
        repeat (2) tick();
        check("t4_abort_pulse", abort_cnt - n0, 1);
        rd_check("t4_busy", A_STAT, exp_stat(1, 0));
        rd_check("t4_no_seg_done", A_STS, {29'd0, m_sts});
        rd_check("t4_ctrl", A_CTRL, exp_ctrl());
        dma_idle = 1'b1;
        repeat (2) tick();
        rd_check("t4_idle", A_STAT, exp_stat(0, 1));

        // Interrupt latency, W1C and overflow edge
        wr_reg(A_EN, 32'h101);
        push_seg("t5_s0", rnd_base(), rnd_len());
        wr_reg(A_CTRL, 32'h31); m_run = 1;
        wait_req("t5_issue");
        dma_idle = 1'b0;
        done_pulse();
        check("t5_itr_cycle1", {31'd0, itr}, 0);
        tick();
        check("t5_itr_cycle2", {31'd0, itr}, 1);
        wr_reg(A_STS, 32'h1); m_sts[0] = 1'b0;
        tick();
        check("t5_itr_cleared", {31'd0, itr}, 0);
        if ($urandom_range(0, 1) == 1) spi_tx_fifo_wt_ovf = 1'b1;
        else spi_rx_fifo_wt_ovf = 1'b1;
        m_sts[2] = 1'b1;
        repeat (2) tick();
        rd_check("t5_sts_ovf", A_STS, {29'd0, m_sts});
        check("t5_itr_masked", {31'd0, itr}, 0);
        spi_tx_fifo_wt_ovf = 1'b0; spi_rx_fifo_wt_ovf = 1'b0;

        // Reset while a segment is outstanding
        push_seg("t6_s0", rnd_base(), rnd_len());
        r = 3'($urandom_range(0, 7));
        dma_idle = 1'b1;
        wr_reg(A_CTRL, {25'd0, r, 4'b0001}); m_rate = r; m_run = 1;
        check("t6_rate_update", {29'd0, audio_sample_rate}, {29'd0, m_rate});
        wait_req("t6_issue");
        dma_idle = 1'b0;
        amba_resetn = 1'b0;
        mq.delete(); m_run = 0; m_loop = 0; m_rate = 3'd3; m_sts = 0;
        #1;
        check("t6_rst_rate", {29'd0, audio_sample_rate}, {29'd0, m_rate});
        check("t6_rst_req", {31'd0, dma_req}, 0);
        check("t6_rst_flash", {flash_rd_baseaddr[7:0], flash_rd_bytes_n}, 0);
        check("t6_rst_itr", {31'd0, itr}, 0);
        tick();
        amba_resetn = 1'b1;
        tick();
        rd_check("t6_stat", A_STAT, exp_stat(0, 0));
        rd_check("t6_ctrl", A_CTRL, exp_ctrl());
        rd_check("t6_sts", A_STS, {29'd0, m_sts});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
